// File: rtl/csa_accum_if.sv
// Handshake bundle for csa_accum: operand stream in, resolved sum out.
interface csa_accum_if #(
  parameter int unsigned W     = 90,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats
  );
endinterface

// File: rtl/csa_accum.sv
// Multi-operand accumulator holding its total in carry-save form; the final
// total is resolved by a CPA_W-bit carry-propagate pass over NCHUNK cycles.
module csa_accum #(
  parameter int unsigned W     = 90,
  parameter int unsigned CPA_W = 30,
  parameter int unsigned CNT_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  input logic        clr,
  csa_accum_if.slave bus
);
  localparam int unsigned NCHUNK = (W + CPA_W - 1) / CPA_W;
  localparam int unsigned PW     = NCHUNK * CPA_W;
  localparam int unsigned KW     = $clog2(NCHUNK + 1);

  localparam logic [1:0] StAcc = 2'd0;
  localparam logic [1:0] StRes = 2'd1;
  localparam logic [1:0] StOut = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     s_q, s_d, c_q, c_d;
  logic [PW-1:0]    res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     x, maj;
  logic [PW-1:0]    s_pad, c_pad;
  logic [CPA_W:0]   slice_sum;
  logic             accept;

  assign bus.in_ready  = (state_q == StAcc) && !clr;
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_sum   = res_q[W-1:0];
  assign bus.out_beats = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  // Subtract as ~x + 1; the +1 rides in the free carry LSB.
  assign x      = bus.in_sub ? ~bus.in_data : bus.in_data;
  assign maj    = (s_q & c_q) | (s_q & x) | (c_q & x);
  assign s_pad  = PW'(s_q);
  assign c_pad  = PW'(c_q);

  always_comb begin
    slice_sum = '0;
    res_d     = res_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        slice_sum = {1'b0, s_pad[i*CPA_W +: CPA_W]} + {1'b0, c_pad[i*CPA_W +: CPA_W]}
                  + (CPA_W + 1)'(cy_q);
        res_d[i*CPA_W +: CPA_W] = slice_sum[CPA_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    k_d     = k_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          s_d   = s_q ^ c_q ^ x;
          c_d   = {maj[W-2:0], bus.in_sub};
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (bus.in_last) begin
            state_d = StRes;
            k_d     = '0;
            cy_d    = 1'b0;
          end
        end
      end
      StRes: begin
        // One extra cycle after the last slice keeps result latency at NCHUNK+1.
        if (k_q == KW'(NCHUNK)) begin
          state_d = StOut;
        end else begin
          cy_d = slice_sum[CPA_W];
          k_d  = k_q + 1'b1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StAcc;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StAcc;
    endcase
    if (clr) begin
      state_d = StAcc;
      s_d     = '0;
      c_d     = '0;
      k_d     = '0;
      cy_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= clr ? '0 : ((state_q == StRes && k_q != KW'(NCHUNK)) ? res_d : res_q);
      k_q     <= k_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
